// File: rtl/alu_ctl_stage.sv
// alu_ctl_stage
//    ID/EX control slice for the EX-stage ALU. It decodes the MIPS instruction
//    currently held in ID into the ALU controls (ALUctl, shiftC, shiftV) and
//    registers them together with a valid bit and an illegal-instruction flag.
//    The ALU therefore always sees stable controls that are aligned to the
//    cycle of the instruction they belong to.
//
// Ports
//    clk       rising-edge clock
//    reset     synchronous, active-high reset; clears the whole slice
//    id_valid  instr holds a real instruction this cycle
//    instr     ID-stage instruction word
//    stall     hold the EX control slice unchanged
//    flush     load a bubble (all outputs zero); takes priority over stall
//    ex_valid  EX slice holds a real instruction
//    ALUctl    ALU operation code
//    shiftC    1 = shift amount is the shamt field (shiftV), 0 = register operands
//    shiftV    shift amount; zero whenever shiftC = 0
//    illegal   the EX instruction did not decode (meaningful only when ex_valid = 1)
module alu_ctl_stage #(
   parameter int         W_INSTR     = 32,
   parameter logic [3:0] ILLEGAL_CTL = 4'b0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [W_INSTR-1:0] instr,
   input  logic               stall,
   input  logic               flush,
   output logic               ex_valid,
   output logic [3:0]         ALUctl,
   output logic               shiftC,
   output logic [4:0]         shiftV,
   output logic               illegal
);

   typedef struct packed {
      logic [3:0] ctl;
      logic       sc;
      logic [4:0] sv;
      logic       ill;
   } dec_t;

   // Pure combinational decode of one instruction word into the ALU controls.
   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d.ctl = ILLEGAL_CTL;
      d.sc  = 1'b0;
      d.sv  = 5'd0;
      d.ill = 1'b0;
      if (w[31:26] == 6'b000000) begin
         unique case (w[5:0])
            6'b000000, 6'b000010, 6'b000011: begin
               // Only the immediate shifts take their amount from shamt.
               d.ctl = (w[5:0] == 6'b000000) ? 4'b0100 :
                       (w[5:0] == 6'b000010) ? 4'b0101 : 4'b1010;
               d.sc  = 1'b1;
               d.sv  = w[10:6];
            end
            6'b000100:            d.ctl = 4'b0100;
            6'b000110:            d.ctl = 4'b1001;
            6'b000111:            d.ctl = 4'b1010;
            6'b100000, 6'b100001: d.ctl = 4'b0010;
            6'b100010, 6'b100011: d.ctl = 4'b0110;
            6'b100100:            d.ctl = 4'b0000;
            6'b100101:            d.ctl = 4'b0001;
            6'b100110:            d.ctl = 4'b1000;
            6'b100111:            d.ctl = 4'b0011;
            6'b101010:            d.ctl = 4'b0111;
            default:              d.ill = 1'b1;
         endcase
      end else begin
         unique case (w[31:26])
            6'b001000, 6'b001001: d.ctl = 4'b0010;
            6'b001100:            d.ctl = 4'b0000;
            6'b001101:            d.ctl = 4'b0001;
            6'b001110:            d.ctl = 4'b1000;
            6'b001010:            d.ctl = 4'b0111;
            6'b001111:            d.ctl = 4'b1111;
            6'b100011, 6'b101011: d.ctl = 4'b0010;
            6'b000100, 6'b000101: d.ctl = 4'b0110;
            default:              d.ill = 1'b1;
         endcase
      end
      // Undecodable words always present the configured illegal code.
      if (d.ill) begin
         d.ctl = ILLEGAL_CTL;
      end
      return d;
   endfunction

   dec_t dec_d;
   logic unused_instr_bits;

   // Register and immediate fields are not needed to pick the ALU operation.
   assign unused_instr_bits = ^instr[25:11];

   always_comb begin
      dec_d = decode(instr[31:0]);
   end

   logic       ex_valid_q;
   logic [3:0] alu_ctl_q;
   logic       shift_c_q;
   logic [4:0] shift_v_q;
   logic       illegal_q;

   // ID -> EX boundary: reset > flush > stall > load (bubble when id_valid = 0).
   always_ff @(posedge clk) begin
      if (reset || flush || (!stall && !id_valid)) begin
         ex_valid_q <= 1'b0;
         alu_ctl_q  <= 4'b0000;
         shift_c_q  <= 1'b0;
         shift_v_q  <= 5'd0;
         illegal_q  <= 1'b0;
      end else if (!stall) begin
         ex_valid_q <= 1'b1;
         alu_ctl_q  <= dec_d.ctl;
         shift_c_q  <= dec_d.sc;
         shift_v_q  <= dec_d.sv;
         illegal_q  <= dec_d.ill;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ALUctl   = alu_ctl_q;
   assign shiftC   = shift_c_q;
   assign shiftV   = shift_v_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_ctl_stage.sv
module tb_alu_ctl_stage;

   localparam logic [3:0] ILL = 4'b0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_valid = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        ex_valid;
   logic [3:0]  ALUctl;
   logic        shiftC;
   logic [4:0]  shiftV;
   logic        illegal;

   alu_ctl_stage #(.W_INSTR(32), .ILLEGAL_CTL(ILL)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .instr(instr),
      .stall(stall), .flush(flush), .ex_valid(ex_valid), .ALUctl(ALUctl),
      .shiftC(shiftC), .shiftV(shiftV), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [3:0] ctl;
      logic       sc;
      logic [4:0] sv;
      logic       ill;
   } exp_t;

   exp_t       sb[$];
   exp_t       mdl;
   exp_t       got;
   exp_t       want;
   logic [3:0] rmap[int];
   logic [3:0] imap[int];
   int         tests = 0;
   int         fails = 0;

   // Reference: table lookup of the instruction set, then the register policy.
   function automatic exp_t ref_dec(input logic [31:0] w);
      exp_t e;
      int   op;
      int   fn;
      op = int'(w[31:26]);
      fn = int'(w[5:0]);
      e = '0;
      e.v = 1'b1;
      if (op == 0) begin
         if (rmap.exists(fn)) begin
            e.ctl = rmap[fn];
            if (fn == 0 || fn == 2 || fn == 3) begin
               e.sc = 1'b1;
               e.sv = w[10:6];
            end
         end else begin
            e.ctl = ILL;
            e.ill = 1'b1;
         end
      end else if (imap.exists(op)) begin
         e.ctl = imap[op];
      end else begin
         e.ctl = ILL;
         e.ill = 1'b1;
      end
      return e;
   endfunction

   task automatic step(input logic r, input logic iv, input logic [31:0] w,
                       input logic st, input logic fl);
      @(negedge clk);
      reset = r; id_valid = iv; instr = w; stall = st; flush = fl;
      if (r || fl)      mdl = '0;
      else if (st)      mdl = mdl;
      else if (!iv)     mdl = '0;
      else              mdl = ref_dec(w);
      sb.push_back(mdl);
   endtask

   // Monitor: one expected slice per clock edge, compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            want = sb.pop_front();
            got  = {ex_valid, ALUctl, shiftC, shiftV, illegal};
            tests++;
            if (got !== want) begin
               fails++;
               $display("FAIL ex_slice t=%0t got v=%b ctl=%b sc=%b sv=%0d ill=%b required v=%b ctl=%b sc=%b sv=%0d ill=%b",
                        $time, got.v, got.ctl, got.sc, got.sv, got.ill,
                        want.v, want.ctl, want.sc, want.sv, want.ill);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   logic [5:0] legal_ops[10] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F, 6'h23, 6'h2B};

   initial begin
      logic [31:0] w;
      logic [5:0]  op;
      rmap[6'b000000] = 4'b0100; rmap[6'b000010] = 4'b0101; rmap[6'b000011] = 4'b1010;
      rmap[6'b000100] = 4'b0100; rmap[6'b000110] = 4'b1001; rmap[6'b000111] = 4'b1010;
      rmap[6'b100000] = 4'b0010; rmap[6'b100001] = 4'b0010;
      rmap[6'b100010] = 4'b0110; rmap[6'b100011] = 4'b0110;
      rmap[6'b100100] = 4'b0000; rmap[6'b100101] = 4'b0001; rmap[6'b100110] = 4'b1000;
      rmap[6'b100111] = 4'b0011; rmap[6'b101010] = 4'b0111;
      imap[6'b001000] = 4'b0010; imap[6'b001001] = 4'b0010; imap[6'b001100] = 4'b0000;
      imap[6'b001101] = 4'b0001; imap[6'b001110] = 4'b1000; imap[6'b001010] = 4'b0111;
      imap[6'b001111] = 4'b1111; imap[6'b100011] = 4'b0010; imap[6'b101011] = 4'b0010;
      imap[6'b000100] = 4'b0110; imap[6'b000101] = 4'b0110;
      mdl = '0;

      // Reset held with a real instruction present, then first load.
      step(1, 1, 32'h00432022, 0, 0);
      step(1, 1, 32'h00432022, 0, 0);
      step(0, 1, 32'h00432022, 0, 0);
      // SLL then SUB, LUI, SRAV, NOP.
      step(0, 1, 32'h00021100, 0, 0);
      step(0, 1, 32'h00432022, 0, 0);
      step(0, 1, 32'h3C011234, 0, 0);
      step(0, 1, 32'h00622007, 0, 0);
      step(0, 1, 32'h00000000, 0, 0);
      step(0, 1, 32'h000217C3, 0, 0);
      step(0, 1, 32'h00021782, 0, 0);
      // Stall hold, then release.
      step(0, 1, 32'h00432022, 0, 0);
      step(0, 1, 32'h00432020, 1, 0);
      step(0, 1, 32'h00432020, 1, 0);
      step(0, 1, 32'h00432020, 0, 0);
      // Flush over stall.
      step(0, 1, 32'h00432020, 1, 1);
      // Illegal opcode, illegal funct, then bubble.
      step(0, 1, 32'hFC000000, 0, 0);
      step(0, 0, 32'hFC000000, 0, 0);
      step(0, 1, 32'h0043203F, 0, 0);
      step(0, 1, 32'h00432022, 1, 0);
      step(0, 0, 32'h00432022, 0, 0);
      // Reset in the middle of a stall.
      step(0, 1, 32'h00021100, 0, 0);
      step(0, 1, 32'h00432020, 1, 0);
      step(1, 1, 32'h00432020, 1, 0);
      step(0, 1, 32'h00432020, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         w  = $urandom;
         op = legal_ops[$urandom_range(0, 9)];
         case ($urandom_range(0, 3))
            0: ;
            1: w[31:26] = op;
            2: begin w[31:26] = 6'd0; w[5:0] = 6'($urandom_range(0, 63)); end
            default: begin w[31:26] = 6'd0; w[5:0] = 6'($urandom_range(0, 7)); end
         endcase
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), w,
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
      end

      step(0, 0, 32'd0, 0, 0);
      repeat (3) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain got %0d pending required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
